mmio_stream_port: RTL and testbench
===================================

// Module: mmio_stream_port
// PURPOSE
//  Memory-mapped responder on the core data bus, beside the RAM. Core stores to a
//  16-byte register window; words written to DATA are buffered in a FIFO and drained
//  to an external valid/ready stream (JPEG bitstream output). Status is readable back.
// PARAMETERS
//  WIDTH      32            data/address width, matches core
//  BASEADDR   32'h0000_1000 window base; must be 16-byte aligned
//  FIFODEPTH  8             FIFO entries; power of 2, >= 2
// PORTS
//  clock    in   1      system clock, rising edge
//  nreset   in   1      asynchronous active-low reset
//  address  in   WIDTH  core ramaddress
//  wdata    in   WIDTH  core writeramdata
//  enw      in   1      core writeram
//  hit      out  1      address inside window (combinational); SoC uses it to mux rdata
//  rdata    out  WIDTH  register read data (combinational); 0 when !hit
//  tdata    out  WIDTH  stream data = FIFO head
//  tvalid   out  1      FIFO not empty
//  tready   in   1      sink accepts; transfer when tvalid & tready
// BEHAVIOUR
//  - Decode: hit = address[WIDTH-1:4] == BASEADDR[WIDTH-1:4]; offset = address[3:2];
//    address[1:0] ignored. Reads are combinational, zero wait; writes take effect at edge.
//  - 0x0 DATA  W: push wdata. R: 0.
//  - 0x4 STATUS R: [0] full, [1] empty, [2] overflow (sticky), [15:8] occupancy. W: ignored.
//  - 0x8 CTRL  W: [0] flush, [1] clear overflow. R: 0.
//  - 0xC reserved (see CONFIGURATION); R: 0, W: ignored.
//  - push = enw & hit & offset==0; pop = tvalid & tready.
//  - Push accepted if !full, or if full and pop same cycle (occupancy stays DEPTH).
//  - Push while full without pop: word dropped, overflow <= 1, FIFO unchanged.
//  - Push into empty FIFO: tvalid rises next cycle (1-cycle latency); tdata stable while
//    tvalid & !tready (AXI-stream rule: no retraction).
//  - Simultaneous push+pop, not full/empty: occupancy unchanged, order preserved.
//  - Flush: pointers and occupancy to 0 next edge; a push in the flush cycle is
//    discarded, not flagged; a pop in the flush cycle is still a valid transfer.
//  - Clear overflow and new overflow same cycle: overflow stays 1 (set wins).
//  - Pointers log2(FIFODEPTH) bits, wrap naturally; occupancy log2(FIFODEPTH)+1 bits.
//  - Reset (async, any time incl. mid-stream): pointers, occupancy, overflow = 0;
//    tvalid = 0, full = 0, empty = 1; FIFO storage not reset; tdata don't-care.
// CONFIGURATION
//  - MMIO_STREAM_COUNT_EN defined: 0xC COUNT R: WIDTH-bit count of stream transfers
//    since reset, wraps at 2^WIDTH; W any value: clear to 0 (clear wins over increment).
//  - Undefined: no counter logic; 0xC reads 0.
// STRUCTURE
//  - Package riscv32s_pkg: register offsets (OFF_DATA/STATUS/CTRL/COUNT), STATUS and CTRL
//    bit positions, window size constant.
//  - Sub-module sync_fifo #(WIDTH, FIFODEPTH): push/pop/flush, full/empty/occupancy,
//    head data out. Top handles decode, registers, overflow, counter.
// TESTING
//  - Reset: nreset low mid-transfer -> tvalid=0, STATUS read = 32'h0000_0002 immediately.
//  - Write 0xA1,0xA2,0xA3 to 0x1000, tready=1 -> tdata 0xA1,0xA2,0xA3 in order, first
//    tvalid one cycle after first store.
//  - tready=0, 9 writes (DEPTH=8) -> STATUS = 32'h0000_0805; 9th word never appears;
//    write CTRL=2 -> STATUS = 32'h0000_0801.
//  - Full FIFO, tready=1 and push same cycle -> push accepted, overflow stays 0.
//  - 4 words queued, CTRL=1 -> next cycle tvalid=0, STATUS = 32'h0000_0002.
//  - Read 0x2000 (outside) -> hit=0, rdata=0; with MMIO_STREAM_COUNT_EN, 5 transfers ->
//    read 0x100C = 5; write 0x100C -> reads 0.

Source files
------------

// File: rtl/riscv32s_pkg.sv
// Shared constants for the MMIO stream port: register word offsets, STATUS/CTRL
// bit positions and the register window size.
package riscv32s_pkg;

    localparam int WINDOW_BYTES = 16;

    // Word index within the window, taken from address[3:2]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_COUNT  = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_OCC_LSB = 8;
    localparam int ST_OCC_W   = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/mmio_stream_port_sync_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally on rdata.
// Storage is not reset, only pointers and occupancy.
module sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int FIFODEPTH = 8
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFODEPTH):0]   occupancy
);

    localparam int AW = $clog2(FIFODEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFODEPTH);

    logic [WIDTH-1:0] mem_q [FIFODEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic             do_push, do_pop;

    assign full      = (occ_q == OCC_FULL);
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign rdata     = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A full FIFO still takes a word when the head leaves in the same cycle
        do_push  = push & (~full | do_pop) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_stream_port.sv
// Memory-mapped register window that buffers DATA stores in a FIFO and drains
// them to a valid/ready stream. Optional transfer counter at 0xC: MMIO_STREAM_COUNT_EN.
module mmio_stream_port
    import riscv32s_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  BASEADDR  = WIDTH'(32'h0000_1000),
    parameter int                FIFODEPTH = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] wdata,
    input  logic             enw,
    output logic             hit,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] tdata,
    output logic             tvalid,
    input  logic             tready
);

    localparam int WIN_LSB = $clog2(WINDOW_BYTES);
    localparam int OCC_W   = $clog2(FIFODEPTH) + 1;

    logic [1:0]       offset;
    logic             push, pop, ctrl_wr, flush, clr_ovf, ovf_set;
    logic             full, empty;
    logic [OCC_W-1:0] occupancy;
    logic [WIDTH-1:0] status;
    logic             ovf_q, ovf_d;
    logic             unused_addr_bits;

    assign hit    = (address[WIDTH-1:WIN_LSB] == BASEADDR[WIDTH-1:WIN_LSB]);
    assign offset = address[WIN_LSB-1:2];
    assign unused_addr_bits = ^address[1:0];

    assign push    = enw & hit & (offset == OFF_DATA);
    assign ctrl_wr = enw & hit & (offset == OFF_CTRL);
    assign flush   = ctrl_wr & wdata[CTRL_FLUSH];
    assign clr_ovf = ctrl_wr & wdata[CTRL_CLR_OVF];
    assign tvalid  = ~empty;
    assign pop     = tvalid & tready;
    // A store dropped by a flush in the same cycle is intentionally not an overflow
    assign ovf_set = push & full & ~pop & ~flush;

    sync_fifo #(
        .WIDTH     (WIDTH),
        .FIFODEPTH (FIFODEPTH)
    ) u_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (wdata),
        .rdata     (tdata),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set)      ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

`ifdef MMIO_STREAM_COUNT_EN
    logic [WIDTH-1:0] count_q, count_d;
    logic             count_clr;

    assign count_clr = enw & hit & (offset == OFF_COUNT);

    always_comb begin
        count_d = count_q;
        if (count_clr) count_d = '0;
        else if (pop)  count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) count_q <= '0;
        else         count_q <= count_d;
    end
`endif

    always_comb begin
        status = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF]   = ovf_q;
        status[ST_OCC_LSB +: OCC_W] = occupancy;
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS: rdata = status;
`ifdef MMIO_STREAM_COUNT_EN
                OFF_COUNT:  rdata = count_q;
`endif
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Randomized and directed bench for mmio_stream_port against a queue-based model
// of the register window and stream FIFO.
module tb_mmio_stream_port;

    localparam int DEPTH = 8;

    logic        clock;
    logic        nreset;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        enw;
    logic        hit;
    logic [31:0] rdata;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic        m_ovf;
    logic [31:0] m_count;

    mmio_stream_port #(
        .WIDTH     (32),
        .BASEADDR  (32'h0000_1000),
        .FIFODEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .nreset  (nreset),
        .address (address),
        .wdata   (wdata),
        .enw     (enw),
        .hit     (hit),
        .rdata   (rdata),
        .tdata   (tdata),
        .tvalid  (tvalid),
        .tready  (tready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[31:4] == 28'h0000100) begin
            case (a[3:2])
                2'd1: r = {16'h0, 8'(mq.size()), 5'h0, m_ovf,
                           (mq.size() == 0), (mq.size() == DEPTH)};
`ifdef MMIO_STREAM_COUNT_EN
                2'd3: r = m_count;
`endif
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic model_update();
        bit in_win, pop, full, push, flush, clr;
        in_win = (address[31:4] == 28'h0000100);
        full   = (mq.size() == DEPTH);
        pop    = (mq.size() != 0) && tready;
        push   = enw && in_win && (address[3:2] == 2'd0);
        flush  = enw && in_win && (address[3:2] == 2'd2) && wdata[0];
        clr    = enw && in_win && (address[3:2] == 2'd2) && wdata[1];
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (push) begin
            if (!full || pop) mq.push_back(wdata);
            else if (!clr || 1'b1) m_ovf = 1'b1;
        end
        if (clr && !(push && full && !pop && !flush)) m_ovf = 1'b0;
        if (enw && in_win && (address[3:2] == 2'd3)) m_count = 32'h0;
        else if (pop) m_count = m_count + 32'd1;
    endtask

    task automatic cycle();
        @(negedge clock);
        check_eq("tvalid", {31'h0, tvalid}, {31'h0, mq.size() != 0});
        if (mq.size() != 0) check_eq("tdata", tdata, mq[0]);
        check_eq("hit", {31'h0, hit}, {31'h0, address[31:4] == 28'h0000100});
        check_eq("rdata", rdata, model_rdata(address));
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wdata   = d;
        enw     = 1'b1;
        cycle();
        enw     = 1'b0;
    endtask

    task automatic idle(input int n);
        enw = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic rd_const(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        enw     = 1'b0;
        #1;
        check_eq(tag, rdata, exp);
        cycle();
    endtask

    task automatic reset_mid();
        enw = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        check_eq("rst_tvalid", {31'h0, tvalid}, 32'h0);
        address = 32'h0000_1004;
        #1;
        check_eq("rst_status", rdata, 32'h0000_0002);
        mq.delete();
        m_ovf   = 1'b0;
        m_count = 32'h0;
        @(posedge clock);
        #1;
        nreset = 1'b1;
    endtask

    initial begin
        nreset  = 1'b0;
        address = 32'h0;
        wdata   = 32'h0;
        enw     = 1'b0;
        tready  = 1'b0;
        m_ovf   = 1'b0;
        m_count = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;

        rd_const("reset_status", 32'h0000_1004, 32'h0000_0002);

        // Ordered delivery, one-cycle latency to tvalid
        tready = 1'b1;
        check_eq("pre_valid", {31'h0, tvalid}, 32'h0);
        wr(32'h0000_1000, 32'hA1);
        check_eq("first_valid", {31'h0, tvalid}, 32'h1);
        check_eq("first_data", tdata, 32'hA1);
        wr(32'h0000_1000, 32'hA2);
        wr(32'h0000_1000, 32'hA3);
        idle(4);

        // Overflow on ninth store, then clear
        tready = 1'b0;
        for (int i = 0; i < 9; i++) wr(32'h0000_1000, 32'hB0 + i);
        rd_const("status_ovf", 32'h0000_1004, 32'h0000_0805);
        wr(32'h0000_1008, 32'h2);
        rd_const("status_clr", 32'h0000_1004, 32'h0000_0801);

        // Push into full FIFO with simultaneous pop is accepted
        tready = 1'b1;
        wr(32'h0000_1000, 32'hC0);
        tready = 1'b0;
        rd_const("full_push_pop", 32'h0000_1004, 32'h0000_0801);
        tready = 1'b1;
        idle(10);

        // Flush
        tready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h0000_1000, 32'hD0 + i);
        wr(32'h0000_1008, 32'h1);
        check_eq("flush_tvalid", {31'h0, tvalid}, 32'h0);
        rd_const("flush_status", 32'h0000_1004, 32'h0000_0002);

        // Outside the window
        address = 32'h0000_2000;
        #1;
        check_eq("outside_hit", {31'h0, hit}, 32'h0);
        check_eq("outside_rdata", rdata, 32'h0);
        wr(32'h0000_2000, 32'hEE);
        idle(2);

        // Reset in the middle of a transfer
        tready = 1'b1;
        for (int i = 0; i < 3; i++) wr(32'h0000_1000, 32'hF0 + i);
        reset_mid();
        idle(2);

`ifdef MMIO_STREAM_COUNT_EN
        tready = 1'b1;
        for (int i = 0; i < 5; i++) wr(32'h0000_1000, 32'h50 + i);
        idle(3);
        rd_const("count5", 32'h0000_100C, 32'h5);
        wr(32'h0000_100C, 32'h1234);
        rd_const("count_clr", 32'h0000_100C, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            enw = ($urandom_range(0, 3) != 0);
            wdata = $urandom;
            if (sel < 7) address = 32'h0000_1000 | 32'($urandom_range(0, 3));
            else if (sel < 9) address = 32'h0000_1004;
            else if (sel < 11) begin
                address = 32'h0000_1008;
                wdata = {30'h0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0)};
            end
            else if (sel < 13) address = 32'h0000_100C;
            else if (sel < 15) address = 32'h0000_2000;
            else address = 32'h0000_1010;
            if (i < 1500) tready = ($urandom_range(0, 3) == 0);
            else          tready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        enw = 1'b0;
        tready = 1'b1;
        idle(DEPTH + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
